imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: DEPTH_BYTES, default 128, byte capacity of the target instruction memory; must be a multiple of 4 and a power of 2.
REQ-002 Port: CLK  in  1  single clock; all state changes on rising edge.
REQ-003 Port: Reset  in  1  synchronous, active-high reset.
REQ-004 Port: start  in  1  one-cycle pulse that arms a new load at byte address 0.
REQ-005 Port: in_valid  in  1  upstream instruction word valid.
REQ-006 Port: in_ready  out  1  loader can accept a word this cycle.
REQ-007 Port: in_word  in  32  instruction word to store.
REQ-008 Port: in_last  in  1  qualifies in_word as the final word of the image.
REQ-009 Port: mem_we  out  1  byte write enable to instruction memory.
REQ-010 Port: mem_addr  out  log2(DEPTH_BYTES)  byte address of the write.
REQ-011 Port: mem_wdata  out  8  byte written.
REQ-012 Port: words_loaded  out  log2(DEPTH_BYTES/4)+1  count of complete words written since start.
REQ-013 Port: busy  out  1  high in ACCEPT and WRITE.
REQ-014 Port: done  out  1  high in DONE.
REQ-015 Port: overflow  out  1  memory filled before in_last was seen.

Function
REQ-016 FSM states: IDLE, ACCEPT, WRITE, DONE.
REQ-017 IDLE/DONE: start=1 -> ACCEPT next cycle; byte pointer, words_loaded, overflow, and byte index are cleared to 0.
REQ-018 ACCEPT: in_ready=1; a transfer occurs when in_valid&in_ready; in_word and in_last are captured; next state is WRITE with byte index 0.
REQ-019 in_ready is 0 in IDLE, WRITE, and DONE; in_valid in those states is ignored without side effects.
REQ-020 WRITE: lasts exactly 4 cycles; each cycle mem_we=1, mem_addr=pointer, and the pointer increments by 1.
REQ-021 Byte order is big-endian: index 0 = word[31:24], 1 = [23:16], 2 = [15:8], 3 = [7:0], written to addresses p, p+1, p+2, p+3. A word read back from bytes p..p+3 in that order reproduces the original.
REQ-022 mem_we=0 outside WRITE; mem_addr and mem_wdata are don't-care when mem_we=0.
REQ-023 After the 4th byte, words_loaded increments by 1. If the captured in_last=1 -> DONE. Else if pointer reached DEPTH_BYTES -> DONE with overflow=1. Else -> ACCEPT.
REQ-024 Pointer wrap: the pointer is never used after reaching DEPTH_BYTES; there is no wrap to 0 within a load.
REQ-025 in_last on the word that exactly fills memory -> DONE with overflow=0.
REQ-026 Latency: word accepted at cycle N; bytes written at N+1..N+4; in_ready high again at N+5. Throughput is 1 word per 5 cycles.
REQ-027 start in ACCEPT or WRITE is ignored; a load in progress cannot be restarted except by Reset.
REQ-028 DONE persists, holding words_loaded and overflow, until start or Reset.

Reset
REQ-029 Reset=1 at an edge -> IDLE. in_ready, mem_we, busy, done, and overflow become 0. words_loaded, pointer, byte index, and mem_addr become 0.
REQ-030 Reset mid-WRITE aborts immediately; no further mem_we pulses. Bytes already written are not rolled back.
REQ-031 Reset has priority over start and in_valid in the same cycle.

Configuration
REQ-032 Macro IMEM_LOADER_CHECKSUM_EN defined: extra output port checksum (out, 8 bits) holds the XOR of every byte written since the last start. It is cleared by start and by Reset, and updated in the cycle after each mem_we.
REQ-033 Macro undefined: no checksum port or logic exists. All other behaviour is identical.

Verification
REQ-034 Reset, start, send 0x8C010004 with in_last=1 -> writes 8C@0, 01@1, 00@2, 04@3 in 4 consecutive cycles; done=1, words_loaded=1, overflow=0.
REQ-035 3 back-to-back words with in_valid held high -> in_ready pulses once every 5 cycles; exactly 12 mem_we pulses at addresses 0..11; words_loaded=3.
REQ-036 DEPTH_BYTES=128, 32 words with no in_last -> DONE after address 127; overflow=1; words_loaded=32; in_ready stays 0 while a 33rd word is held valid.
REQ-037 Same run with in_last on word 32 -> overflow=0, done=1.
REQ-038 Reset asserted on the 2nd WRITE cycle of word 0xAABBCCDD -> only AA@0 and BB@1 are written. All outputs are 0 the next cycle, and a subsequent start reloads from address 0.
REQ-039 With IMEM_LOADER_CHECKSUM_EN defined, words 0x01020304 and 0x10203040 with in_last=1 -> checksum=0x44; a new start clears it to 0x00.

Source files
------------

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Purpose  : Accepts 32-bit instruction words over a valid/ready stream and
//            writes each one into a byte-wide instruction memory as four
//            big-endian bytes on consecutive cycles.
// Ports    : CLK, Reset        clock, synchronous active-high reset
//            start             pulse that arms a new load at byte address 0
//            in_valid/in_ready/in_word/in_last   upstream word stream
//            mem_we/mem_addr/mem_wdata           byte write port
//            words_loaded      complete words written since start
//            busy/done         status (ACCEPT or WRITE / DONE)
//            overflow          memory filled before in_last was seen
//            checksum          (IMEM_LOADER_CHECKSUM_EN only) XOR of bytes
// Options  : define IMEM_LOADER_CHECKSUM_EN to add the checksum output.
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int DEPTH_BYTES = 128
) (
    input  logic                           CLK,
    input  logic                           Reset,
    input  logic                           start,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [31:0]                    in_word,
    input  logic                           in_last,
    output logic                           mem_we,
    output logic [$clog2(DEPTH_BYTES)-1:0] mem_addr,
    output logic [7:0]                     mem_wdata,
    output logic [$clog2(DEPTH_BYTES)-2:0] words_loaded,
    output logic                           busy,
    output logic                           done,
    output logic                           overflow
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    output logic [7:0]                     checksum
`endif
);

    localparam int AW = $clog2(DEPTH_BYTES);
    localparam int WW = AW - 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_WRITE  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t          r_state_q, w_state_d;
    logic [AW-1:0]   r_ptr_q,   w_ptr_d;
    logic [1:0]      r_idx_q,   w_idx_d;
    logic [31:0]     r_word_q,  w_word_d;
    logic            r_last_q,  w_last_d;
    logic [WW-1:0]   r_wcnt_q,  w_wcnt_d;
    logic            r_ovf_q,   w_ovf_d;
    logic [7:0]      r_wdata_q, w_wdata_d;
    logic            r_ready_q, r_we_q, r_busy_q, r_done_q;
    logic            w_arm;
    logic            w_full;

    // Words are 4-byte aligned, so the top address is only ever reached on the
    // last byte of a word.
    assign w_full = (r_ptr_q == AW'(DEPTH_BYTES - 1));
    assign w_arm  = start && ((r_state_q == ST_IDLE) || (r_state_q == ST_DONE));

    always_comb begin
        w_state_d = r_state_q;
        w_ptr_d   = r_ptr_q;
        w_idx_d   = r_idx_q;
        w_word_d  = r_word_q;
        w_last_d  = r_last_q;
        w_wcnt_d  = r_wcnt_q;
        w_ovf_d   = r_ovf_q;
        case (r_state_q)
            ST_IDLE, ST_DONE: begin
                if (w_arm) begin
                    w_state_d = ST_ACCEPT;
                    w_ptr_d   = '0;
                    w_idx_d   = 2'd0;
                    w_wcnt_d  = '0;
                    w_ovf_d   = 1'b0;
                end
            end
            ST_ACCEPT: begin
                if (in_valid) begin
                    w_word_d  = in_word;
                    w_last_d  = in_last;
                    w_idx_d   = 2'd0;
                    w_state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                w_idx_d = r_idx_q + 2'd1;
                // The pointer parks on the top address instead of wrapping.
                if (!w_full) begin
                    w_ptr_d = r_ptr_q + AW'(1);
                end
                if (r_idx_q == 2'd3) begin
                    w_wcnt_d = r_wcnt_q + WW'(1);
                    if (r_last_q) begin
                        w_state_d = ST_DONE;
                    end else if (w_full) begin
                        w_state_d = ST_DONE;
                        w_ovf_d   = 1'b1;
                    end else begin
                        w_state_d = ST_ACCEPT;
                    end
                end
            end
            default: w_state_d = ST_IDLE;
        endcase

        // Byte presented next cycle, most significant byte first.
        case (w_idx_d)
            2'd0:    w_wdata_d = w_word_d[31:24];
            2'd1:    w_wdata_d = w_word_d[23:16];
            2'd2:    w_wdata_d = w_word_d[15:8];
            default: w_wdata_d = w_word_d[7:0];
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state_q <= ST_IDLE;
            r_ptr_q   <= '0;
            r_idx_q   <= 2'd0;
            r_word_q  <= '0;
            r_last_q  <= 1'b0;
            r_wcnt_q  <= '0;
            r_ovf_q   <= 1'b0;
            r_wdata_q <= '0;
            r_ready_q <= 1'b0;
            r_we_q    <= 1'b0;
            r_busy_q  <= 1'b0;
            r_done_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_ptr_q   <= w_ptr_d;
            r_idx_q   <= w_idx_d;
            r_word_q  <= w_word_d;
            r_last_q  <= w_last_d;
            r_wcnt_q  <= w_wcnt_d;
            r_ovf_q   <= w_ovf_d;
            r_wdata_q <= w_wdata_d;
            r_ready_q <= (w_state_d == ST_ACCEPT);
            r_we_q    <= (w_state_d == ST_WRITE);
            r_busy_q  <= (w_state_d == ST_ACCEPT) || (w_state_d == ST_WRITE);
            r_done_q  <= (w_state_d == ST_DONE);
        end
    end

    assign in_ready     = r_ready_q;
    assign mem_we       = r_we_q;
    assign mem_addr     = r_ptr_q;
    assign mem_wdata    = r_wdata_q;
    assign words_loaded = r_wcnt_q;
    assign busy         = r_busy_q;
    assign done         = r_done_q;
    assign overflow     = r_ovf_q;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] r_cksum_q, w_cksum_d;

    // Folds in each byte the cycle after it appears on the write port.
    always_comb begin
        w_cksum_d = r_cksum_q;
        if (w_arm) begin
            w_cksum_d = 8'h00;
        end else if (r_we_q) begin
            w_cksum_d = r_cksum_q ^ r_wdata_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_cksum_q <= 8'h00;
        end else begin
            r_cksum_q <= w_cksum_d;
        end
    end

    assign checksum = r_cksum_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Purpose  : Self-checking bench for imem_loader (fixed vectors, directed
//            multi-cycle sequences and randomized loads against a
//            transaction-level model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam int DEPTH = 128;
    localparam int AW    = $clog2(DEPTH);
    localparam int NW    = DEPTH / 4;

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          start    = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_last  = 1'b0;
    logic [31:0]   in_word  = 32'h0;
    logic          in_ready, mem_we, busy, done, overflow;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic [AW-2:0] words_loaded;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]    checksum;
`endif

    int checks   = 0;
    int failures = 0;

    // Transaction-level model of one load.
    int         m_ptr;
    int         m_words;
    logic [7:0] m_ck;
    bit         m_done;
    bit         m_ovf;

    // Bytes seen on the DUT write port, and number of write pulses.
    logic [7:0]  shadow [DEPTH];
    int          we_count = 0;
    logic [31:0] sent [NW];

    always #5 clk = ~clk;

    imem_loader #(.DEPTH_BYTES(DEPTH)) dut (
        .CLK          (clk),
        .Reset        (rst),
        .start        (start),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_word      (in_word),
        .in_last      (in_last),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .words_loaded (words_loaded),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow)
`ifdef IMEM_LOADER_CHECKSUM_EN
        ,
        .checksum     (checksum)
`endif
    );

    always @(posedge clk) begin
        if (mem_we) begin
            shadow[mem_addr] <= mem_wdata;
            we_count         <= we_count + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] be_byte(input logic [31:0] w, input int k);
        return 8'((w >> (8 * (3 - k))) & 32'hFF);
    endfunction

    task automatic chk_all_zero(input string nm);
        chk({nm, "_ready"}, 32'(in_ready), 0);
        chk({nm, "_we"},    32'(mem_we), 0);
        chk({nm, "_busy"},  32'(busy), 0);
        chk({nm, "_done"},  32'(done), 0);
        chk({nm, "_ovf"},   32'(overflow), 0);
        chk({nm, "_words"}, 32'(words_loaded), 0);
        chk({nm, "_addr"},  32'(mem_addr), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        m_ptr = 0; m_words = 0; m_ck = 8'h00; m_done = 1'b0; m_ovf = 1'b0;
        chk_all_zero("reset");
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        m_ptr = 0; m_words = 0; m_ck = 8'h00; m_done = 1'b0; m_ovf = 1'b0;
        chk("start_ready", 32'(in_ready), 1);
        chk("start_busy",  32'(busy), 1);
        chk("start_done",  32'(done), 0);
        chk("start_words", 32'(words_loaded), 0);
        chk("start_ovf",   32'(overflow), 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk("start_cksum", 32'(checksum), 0);
`endif
    endtask

    // One word through the loader; noise drives start/in_valid where they
    // must be ignored.
    task automatic send_word(input logic [31:0] w, input bit last, input int gap, input bit noise);
        logic [7:0] b;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            start    = noise && ($urandom_range(0, 1) == 1);
            chk("wait_ready", 32'(in_ready), 1);
            chk("wait_we",    32'(mem_we), 0);
            tick();
        end
        start    = noise && ($urandom_range(0, 1) == 1);
        in_valid = 1'b1;
        in_word  = w;
        in_last  = last;
        chk("accept_ready", 32'(in_ready), 1);
        chk("accept_words", 32'(words_loaded), 32'(m_words));
        tick();
        for (int k = 0; k < 4; k++) begin
            b        = be_byte(w, k);
            start    = noise && ($urandom_range(0, 1) == 1);
            in_valid = noise && ($urandom_range(0, 1) == 1);
            in_word  = $urandom;
            in_last  = 1'($urandom_range(0, 1));
            chk("wr_we",    32'(mem_we), 1);
            chk("wr_addr",  32'(mem_addr), 32'(m_ptr));
            chk("wr_data",  32'(mem_wdata), 32'(b));
            chk("wr_ready", 32'(in_ready), 0);
            chk("wr_busy",  32'(busy), 1);
            m_ck  = m_ck ^ b;
            m_ptr = m_ptr + 1;
            tick();
        end
        start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        m_words++;
        if (last) begin
            m_done = 1'b1;
        end else if (m_ptr == DEPTH) begin
            m_done = 1'b1;
            m_ovf  = 1'b1;
        end
        chk("post_words", 32'(words_loaded), 32'(m_words));
        chk("post_done",  32'(done), 32'(m_done));
        chk("post_ovf",   32'(overflow), 32'(m_ovf));
        chk("post_ready", 32'(in_ready), 32'(!m_done));
        chk("post_busy",  32'(busy), 32'(!m_done));
        chk("post_we",    32'(mem_we), 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk("post_cksum", 32'(checksum), 32'(m_ck));
`endif
    endtask

    typedef struct {
        logic [31:0] word;
        logic [7:0]  b [4];
    } vec_t;

    initial begin
        vec_t tbl [5];
        logic [31:0] bw [3];
        int n_ready, n_we, lastpos, we_before;

        tbl[0] = '{word: 32'h8C010004, b: '{8'h8C, 8'h01, 8'h00, 8'h04}};
        tbl[1] = '{word: 32'h11223344, b: '{8'h11, 8'h22, 8'h33, 8'h44}};
        tbl[2] = '{word: 32'hDEADBEEF, b: '{8'hDE, 8'hAD, 8'hBE, 8'hEF}};
        tbl[3] = '{word: 32'h00000000, b: '{8'h00, 8'h00, 8'h00, 8'h00}};
        tbl[4] = '{word: 32'hFF00A55A, b: '{8'hFF, 8'h00, 8'hA5, 8'h5A}};

        do_reset();

        // Single-word images from the fixed table.
        for (int i = 0; i < 5; i++) begin
            do_start();
            in_valid = 1'b1; in_word = tbl[i].word; in_last = 1'b1;
            tick();
            in_valid = 1'b0; in_last = 1'b0;
            for (int k = 0; k < 4; k++) begin
                chk("tbl_we",   32'(mem_we), 1);
                chk("tbl_addr", 32'(mem_addr), 32'(k));
                chk("tbl_data", 32'(mem_wdata), 32'(tbl[i].b[k]));
                tick();
            end
            chk("tbl_done",  32'(done), 1);
            chk("tbl_words", 32'(words_loaded), 1);
            chk("tbl_ovf",   32'(overflow), 0);
            chk("tbl_busy",  32'(busy), 0);
        end

        // Three words with in_valid held high: one accept every 5 cycles.
        bw[0] = 32'hA1B2C3D4; bw[1] = 32'h0F1E2D3C; bw[2] = 32'h55667788;
        do_start();
        n_ready = 0; n_we = 0;
        for (int c = 0; c < 15; c++) begin
            in_valid = 1'b1;
            in_word  = bw[c / 5];
            in_last  = (c / 5 == 2);
            chk("b2b_ready", 32'(in_ready), 32'(c % 5 == 0));
            chk("b2b_we",    32'(mem_we), 32'(c % 5 != 0));
            if (c % 5 != 0) begin
                chk("b2b_addr", 32'(mem_addr), 32'(4 * (c / 5) + (c % 5) - 1));
                chk("b2b_data", 32'(mem_wdata), 32'(be_byte(bw[c / 5], (c % 5) - 1)));
            end
            n_ready += int'(in_ready);
            n_we    += int'(mem_we);
            tick();
        end
        in_valid = 1'b0; in_last = 1'b0;
        chk("b2b_nready", 32'(n_ready), 3);
        chk("b2b_nwe",    32'(n_we), 12);
        chk("b2b_words",  32'(words_loaded), 3);
        chk("b2b_done",   32'(done), 1);

        // Fill memory without in_last: overflow.
        do_start();
        for (int j = 0; j < NW; j++) send_word(32'h01000000 * j + 32'h00010203, 1'b0, 0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1; in_word = 32'hCAFEF00D;
            chk("ovf_ready", 32'(in_ready), 0);
            chk("ovf_we",    32'(mem_we), 0);
            chk("ovf_done",  32'(done), 1);
            chk("ovf_flag",  32'(overflow), 1);
            chk("ovf_words", 32'(words_loaded), 32);
            tick();
        end
        in_valid = 1'b0;

        // in_last on the word that exactly fills memory.
        do_start();
        for (int j = 0; j < NW; j++) send_word($urandom, (j == NW - 1), 0, 1'b0);
        chk("fill_ovf",   32'(overflow), 0);
        chk("fill_done",  32'(done), 1);
        chk("fill_words", 32'(words_loaded), 32);

        // Reset during the second byte of a word.
        do_start();
        we_before = we_count;
        in_valid = 1'b1; in_word = 32'hAABBCCDD; in_last = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("rmw_addr0", 32'(mem_addr), 0);
        chk("rmw_data0", 32'(mem_wdata), 32'hAA);
        tick();
        chk("rmw_addr1", 32'(mem_addr), 1);
        chk("rmw_data1", 32'(mem_wdata), 32'hBB);
        rst = 1'b1; start = 1'b1; in_valid = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0; in_valid = 1'b0;
        chk_all_zero("rmw");
        chk("rmw_wdata", 32'(mem_wdata), 0);
        tick();
        tick();
        tick();
        chk("rmw_pulses", 32'(we_count - we_before), 2);
        chk("rmw_shadow0", 32'(shadow[0]), 32'hAA);
        chk("rmw_shadow1", 32'(shadow[1]), 32'hBB);
        m_done = 1'b0; m_ovf = 1'b0; m_words = 0;
        do_start();
        send_word(32'h12345678, 1'b1, 0, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        do_start();
        send_word(32'h01020304, 1'b0, 0, 1'b0);
        send_word(32'h10203040, 1'b1, 0, 1'b0);
        chk("cksum_value", 32'(checksum), 32'h44);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("cksum_clear", 32'(checksum), 32'h00);
        m_ptr = 0; m_words = 0; m_ck = 8'h00; m_done = 1'b0; m_ovf = 1'b0;
        send_word(32'h0000FF00, 1'b1, 0, 1'b0);
`endif

        // Randomized loads: gaps, ignored start/in_valid, random image length.
        for (int l = 0; l < 12; l++) begin
            for (int g = 0; g < 3; g++) begin
                in_valid = 1'($urandom_range(0, 1));
                in_word  = $urandom;
                chk("rnd_idle_ready", 32'(in_ready), 0);
                chk("rnd_idle_we",    32'(mem_we), 0);
                chk("rnd_idle_done",  32'(done), 32'(m_done));
                chk("rnd_idle_words", 32'(words_loaded), 32'(m_words));
                tick();
            end
            in_valid = 1'b0;
            do_start();
            lastpos = (l % 4 == 3) ? 40 : int'($urandom_range(1, 34));
            for (int j = 1; !m_done; j++) begin
                sent[m_ptr / 4] = $urandom;
                send_word(sent[m_ptr / 4], (j == lastpos), int'($urandom_range(0, 3)), 1'b1);
            end
            tick();
            for (int j = 0; j < m_words; j++) begin
                chk("rnd_readback",
                    {shadow[4 * j], shadow[4 * j + 1], shadow[4 * j + 2], shadow[4 * j + 3]},
                    sent[j]);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
